multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have no parameters; all encodings below are fixed.
REQ-002 clk  input  1  rising-edge system clock, sole clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Opcode  input  6  instruction[31:26] from instruction register.
REQ-005 Funct  input  6  instruction[5:0] from instruction register.
REQ-006 MemReady  input  1  memory has completed current read/write this cycle.
REQ-007 ALUOp  output  3  ALU-control class: 111 R-type, 011 add, 001 or, 000 and/lw/sw, 101 lui, 100 sub/branch, 110 jal.
REQ-008 PCWrite  output  1  unconditional PC load.
REQ-009 PCWriteCond  output  1  conditional PC load (branch).
REQ-010 BranchNE  output  1  branch taken on !Zero instead of Zero.
REQ-011 PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump address, 11 rs register.
REQ-012 IorD  output  1  memory address select: 0 PC, 1 ALUOut.
REQ-013 MemRead / MemWrite  output  1 each  memory strobes.
REQ-014 IRWrite  output  1  instruction register load.
REQ-015 RegWrite  output  1  register file write.
REQ-016 RegDst  output  2  00 rt, 01 rd, 10 $ra (31).
REQ-017 MemtoReg  output  2  00 ALUOut, 01 MDR, 10 PC.
REQ-018 ALUSrcA  output  1  0 PC, 1 rs.  ALUSrcB  output  2  00 rt, 01 const 4, 10 sign/zero-ext imm, 11 imm<<2.
REQ-019 IllegalOp  output  1  one-cycle pulse on undecodable instruction.
REQ-020 State  output  3  current state for debug.

Function
REQ-021 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, JUMP=6; code 7 SHALL return to FETCH next cycle.
REQ-022 Outputs SHALL be decoded combinationally from State and the latched Opcode/Funct (Moore); unlisted outputs 0 in each state.
REQ-023 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=011; hold while MemReady=0; when MemReady=1 same cycle IRWrite=1, PCWrite=1, PCSource=00, next DECODE.
REQ-024 DECODE: latch Opcode and Funct internally; ALUSrcA=0, ALUSrcB=11, ALUOp=011 (branch target).
REQ-025 DECODE next: R-type (00, Funct!=08) , addi 08, andi 0C, ori 0D, lui 0F, lw 23, sw 2B -> EXEC; beq 04, bne 05 -> BRANCH; j 02, jal 03, R-type Funct=08 (jr) -> JUMP; any other opcode -> FETCH with IllegalOp=1 for that DECODE cycle.
REQ-026 EXEC: ALUSrcA=1; ALUSrcB=00 for R-type else 10; ALUOp 111 R, 011 addi/lw/sw, 000 andi, 001 ori, 101 lui; next MEM for lw/sw, else WB.
REQ-027 MEM: IorD=1; MemRead=1 (lw) or MemWrite=1 (sw) held while MemReady=0; on MemReady=1 lw -> WB, sw -> FETCH.
REQ-028 WB: RegWrite=1; RegDst=01 for R-type else 00; MemtoReg=01 for lw else 00; next FETCH.
REQ-029 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=100, PCWriteCond=1, PCSource=01, BranchNE=1 only for bne; next FETCH.
REQ-030 JUMP: j -> PCWrite=1, PCSource=10; jal -> additionally RegWrite=1, RegDst=10, MemtoReg=10, ALUOp=110; jr -> PCWrite=1, PCSource=11; next FETCH.
REQ-031 Latency with MemReady=1 on first cycle of each wait: R/I-ALU 4 cycles, lw 5, sw 4, beq/bne 3, j/jal/jr 3.
REQ-032 MemReady SHALL be ignored outside FETCH and MEM.
REQ-033 Opcode/Funct changes after DECODE SHALL NOT affect decoding until next DECODE.

Reset
REQ-034 While reset=1 on a clock edge, State SHALL become FETCH and latched Opcode/Funct 000000.
REQ-035 While reset=1, all strobe outputs (PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite, IllegalOp) SHALL be forced 0; selects at 0.
REQ-036 Reset asserted mid-instruction (including MEM wait) SHALL abort it with no further strobes; first cycle after release is FETCH.

Verification
REQ-037 add (Opcode 00, Funct 20), MemReady=1 -> states 0,1,2,4,0; EXEC ALUOp=111; WB RegWrite=1, RegDst=01.
REQ-038 lw (23), MemReady low 3 cycles in MEM -> MemRead held 4 MEM cycles, IorD=1; then WB MemtoReg=01, RegWrite=1.
REQ-039 bne (05) -> BRANCH with ALUOp=100, PCWriteCond=1, BranchNE=1, PCSource=01; beq same with BranchNE=0.
REQ-040 jal (03) -> JUMP with RegWrite=1, RegDst=10, MemtoReg=10, PCSource=10, ALUOp=110; jr (00/08) -> PCSource=11, RegWrite=0.
REQ-041 Opcode 3F -> IllegalOp pulse in DECODE, next state FETCH, no RegWrite/MemWrite.
REQ-042 reset pulsed during sw MEM wait -> MemWrite 0 same cycle, State=0 after edge, fetch resumes on release.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit: seven-state FSM with Moore-decoded datapath controls.
// Opcode/Funct are captured at the end of DECODE, so later states ignore any changes on those inputs.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output logic [2:0] ALUOp,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNE,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       IllegalOp,
    output logic [2:0] State
);

    localparam int unsigned OP_W = 6;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_JUMP   = 3'd6,
        S_SPARE  = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_RTYPE, C_ADDI, C_ANDI, C_ORI, C_LUI, C_LW, C_SW,
        C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_ILLEGAL
    } class_t;

    // Map an opcode/funct pair to its instruction class.
    function automatic class_t classify(input logic [OP_W-1:0] op, input logic [OP_W-1:0] fn);
        class_t c;
        case (op)
            6'h00:   c = (fn == 6'h08) ? C_JR : C_RTYPE;
            6'h08:   c = C_ADDI;
            6'h0C:   c = C_ANDI;
            6'h0D:   c = C_ORI;
            6'h0F:   c = C_LUI;
            6'h23:   c = C_LW;
            6'h2B:   c = C_SW;
            6'h04:   c = C_BEQ;
            6'h05:   c = C_BNE;
            6'h02:   c = C_J;
            6'h03:   c = C_JAL;
            default: c = C_ILLEGAL;
        endcase
        return c;
    endfunction

    state_t            state_q, state_d;
    logic [OP_W-1:0]   op_q, fn_q;
    class_t            live_cls, held_cls;

    assign live_cls = classify(Opcode, Funct);
    assign held_cls = classify(op_q, fn_q);
    assign State    = state_q;

    // State register and instruction-field capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            fn_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= Opcode;
                fn_q <= Funct;
            end
        end
    end

    // Next-state and control decode; everything stays at zero while reset is high.
    always_comb begin
        state_d     = state_q;
        ALUOp       = 3'b000;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNE    = 1'b0;
        PCSource    = 2'b00;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        IllegalOp   = 1'b0;

        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    ALUOp   = 3'b011;
                    if (MemReady) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        state_d = S_DECODE;
                    end
                end

                // Decode sees the live instruction fields; they are captured on this edge.
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    ALUOp   = 3'b011;
                    case (live_cls)
                        C_ILLEGAL: begin
                            IllegalOp = 1'b1;
                            state_d   = S_FETCH;
                        end
                        C_BEQ, C_BNE:     state_d = S_BRANCH;
                        C_J, C_JAL, C_JR: state_d = S_JUMP;
                        default:          state_d = S_EXEC;
                    endcase
                end

                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = (held_cls == C_RTYPE) ? 2'b00 : 2'b10;
                    case (held_cls)
                        C_RTYPE: ALUOp = 3'b111;
                        C_ANDI:  ALUOp = 3'b000;
                        C_ORI:   ALUOp = 3'b001;
                        C_LUI:   ALUOp = 3'b101;
                        default: ALUOp = 3'b011;
                    endcase
                    state_d = (held_cls == C_LW || held_cls == C_SW) ? S_MEM : S_WB;
                end

                S_MEM: begin
                    IorD     = 1'b1;
                    MemRead  = (held_cls == C_LW);
                    MemWrite = (held_cls == C_SW);
                    if (MemReady) begin
                        state_d = (held_cls == C_LW) ? S_WB : S_FETCH;
                    end
                end

                S_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = (held_cls == C_RTYPE) ? 2'b01 : 2'b00;
                    MemtoReg = (held_cls == C_LW) ? 2'b01 : 2'b00;
                    state_d  = S_FETCH;
                end

                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUSrcB     = 2'b00;
                    ALUOp       = 3'b100;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    BranchNE    = (held_cls == C_BNE);
                    state_d     = S_FETCH;
                end

                S_JUMP: begin
                    PCWrite = 1'b1;
                    case (held_cls)
                        C_JR: PCSource = 2'b11;
                        C_JAL: begin
                            PCSource = 2'b10;
                            RegWrite = 1'b1;
                            RegDst   = 2'b10;
                            MemtoReg = 2'b10;
                            ALUOp    = 3'b110;
                        end
                        default: PCSource = 2'b10;
                    endcase
                    state_d = S_FETCH;
                end

                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule
